// File: rtl/seq_detector_prog_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    IDLE  = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int MAX_LEN_DEFAULT = 16;
  localparam int LEN_W           = len_w(MAX_LEN_DEFAULT);

endpackage

// File: rtl/seq_detector_prog_if.sv
// Config, serial data and status bundle of the pattern detector.
interface seq_detector_prog_if #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 16
);
  import seq_det_pkg::*;

  localparam int LW = len_w(MAX_LEN);

  // cfg_we and din_valid are single-cycle qualifiers with no back-pressure:
  // each cycle they are high is consumed, and cfg_we has priority over din_valid.
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               cfg_overlap;
  logic               enable;
  logic               din_valid;
  logic               din;
  logic               clr_count;
  logic               detect;
  logic [CNT_W-1:0]   match_count;
  logic               armed;
  logic               cfg_err;
  state_t             state;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, enable, din_valid, din, clr_count,
    input  detect, match_count, armed, cfg_err, state
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, enable, din_valid, din, clr_count,
    output detect, match_count, armed, cfg_err, state
  );

endinterface

// File: rtl/seq_detector_prog_sat_counter.sv
// Saturating up-counter; clear together with increment loads one.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? W'(1) : '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector with overlap control
// and a saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 16
) (
  input logic               clk,
  input logic               rst,
  seq_detector_prog_if.slave bus
);

  localparam int LW = len_w(MAX_LEN);

  state_t             state;
  logic [MAX_LEN-1:0] pattern;
  logic [LW-1:0]      len;
  logic               overlap;
  // Only MAX_LEN-1 older bits are stored; the incoming bit completes the window.
  logic [MAX_LEN-2:0] hist;
  logic [LW-1:0]      fill;
  logic               detect_r;
  logic               armed_r;
  logic               cfg_err_r;

  logic               len_ok;
  logic               cfg_ok;
  logic               accept;
  logic [MAX_LEN-1:0] hist_next;
  logic [LW-1:0]      fill_next;
  logic [MAX_LEN-1:0] mask;
  logic               match;

  always_comb begin
    len_ok    = (bus.cfg_len != '0) && (bus.cfg_len <= LW'(MAX_LEN));
    cfg_ok    = bus.cfg_we && len_ok;
    accept    = (state == RUN) && bus.din_valid && !bus.cfg_we;
    hist_next = {hist, bus.din};
    fill_next = (fill == LW'(MAX_LEN)) ? fill : fill + LW'(1);
    mask      = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    match = accept && (fill_next >= len) && (((hist_next ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= UNCFG;
      pattern   <= '0;
      len       <= '0;
      overlap   <= 1'b0;
      hist      <= '0;
      fill      <= '0;
      detect_r  <= 1'b0;
      armed_r   <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      detect_r  <= match;
      cfg_err_r <= bus.cfg_we && !len_ok;
      if (cfg_ok) begin
        pattern <= bus.cfg_pattern;
        len     <= bus.cfg_len;
        overlap <= bus.cfg_overlap;
        hist    <= '0;
        fill    <= '0;
        if (state == UNCFG) state <= IDLE;
      end else begin
        case (state)
          UNCFG: ;
          IDLE: begin
            if (bus.enable) begin
              state   <= RUN;
              armed_r <= 1'b1;
            end
          end
          RUN: begin
            if (!bus.enable) begin
              state   <= IDLE;
              armed_r <= 1'b0;
              hist    <= '0;
              fill    <= '0;
            end else if (accept) begin
              hist <= hist_next[MAX_LEN-2:0];
              fill <= (match && !overlap) ? '0 : fill_next;
            end
          end
          default: begin
            state   <= UNCFG;
            armed_r <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match),
    .clr (bus.clr_count),
    .q   (bus.match_count)
  );

  assign bus.detect  = detect_r;
  assign bus.armed   = armed_r;
  assign bus.cfg_err = cfg_err_r;
  assign bus.state   = state;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench: vector table, corner-case sequences and randomized
// traffic against a queue-based reference model.
module tb_seq_detector_prog;
  import seq_det_pkg::*;

  localparam int ML   = 16;
  localparam int CW   = 16;
  localparam int ML_B = 4;
  localparam int CW_B = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_detector_prog_if #(.MAX_LEN(ML),   .CNT_W(CW))   bus_a ();
  seq_detector_prog_if #(.MAX_LEN(ML_B), .CNT_W(CW_B)) bus_b ();

  seq_detector_prog #(.MAX_LEN(ML),   .CNT_W(CW))   dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  seq_detector_prog #(.MAX_LEN(ML_B), .CNT_W(CW_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted bits since the last clear, newest at the back.
  int            m_state;  // 0 unconfigured, 1 idle, 2 running
  logic [ML-1:0] m_pat;
  int            m_len;
  bit            m_ovl;
  bit            bit_q[$];
  int            m_cnt;
  bit            e_det, e_err, e_arm;

  task automatic model_reset();
    m_state = 0; m_pat = '0; m_len = 0; m_ovl = 0;
    bit_q.delete();
    m_cnt = 0; e_det = 0; e_err = 0; e_arm = 0;
  endtask

  task automatic step();
    int L;
    bit ok, acc, mt;
    bit tq[$];
    L   = int'(bus_a.cfg_len);
    ok  = (L >= 1) && (L <= ML);
    acc = (m_state == 2) && bus_a.din_valid && !bus_a.cfg_we;
    mt  = 0;
    tq  = bit_q;
    if (acc) begin
      tq.push_back(bus_a.din);
      if (tq.size() > ML) void'(tq.pop_front());
      if (tq.size() >= m_len) begin
        mt = 1;
        for (int i = 0; i < m_len; i++)
          if (tq[tq.size()-1-i] != m_pat[i]) mt = 0;
      end
    end
    if (bus_a.cfg_we && ok) begin
      m_pat = bus_a.cfg_pattern; m_len = L; m_ovl = bus_a.cfg_overlap;
      bit_q.delete();
      if (m_state == 0) m_state = 1;
    end else if (m_state == 1 && bus_a.enable) begin
      m_state = 2;
    end else if (m_state == 2 && !bus_a.enable) begin
      m_state = 1;
      bit_q.delete();
    end else if (acc) begin
      bit_q = tq;
      if (mt && !m_ovl) bit_q.delete();
    end
    if (bus_a.clr_count) m_cnt = mt ? 1 : 0;
    else if (mt && m_cnt < (1 << CW) - 1) m_cnt++;
    e_det = mt;
    e_err = bus_a.cfg_we && !ok;
    e_arm = (m_state == 2);
    @(posedge clk); #1;
    chk("detect",  bus_a.detect,      e_det);
    chk("count",   bus_a.match_count, m_cnt);
    chk("armed",   bus_a.armed,       e_arm);
    chk("cfg_err", bus_a.cfg_err,     e_err);
  endtask

  task automatic configure(input int len, input logic [ML-1:0] pat, input bit ovl);
    bus_a.cfg_we = 1'b1; bus_a.cfg_len = len[4:0]; bus_a.cfg_pattern = pat; bus_a.cfg_overlap = ovl;
    step();
    bus_a.cfg_we = 1'b0;
  endtask

  task automatic send_bit(input bit b);
    bus_a.din_valid = 1'b1; bus_a.din = b;
    step();
    bus_a.din_valid = 1'b0;
  endtask

  task automatic clear_cnt();
    bus_a.clr_count = 1'b1;
    step();
    bus_a.clr_count = 1'b0;
  endtask

  typedef struct {
    bit ovl;
    bit din;
    bit exp_det;
    int exp_cnt;
  } vec_t;

  vec_t tbl[14];
  int   sat_exp[6];
  bit   gap_bits[3];

  initial begin
    tbl = '{'{1,0,0,0}, '{1,1,0,0}, '{1,1,0,0}, '{1,0,1,1}, '{1,1,0,1}, '{1,1,0,1}, '{1,0,1,2},
            '{0,0,0,0}, '{0,1,0,0}, '{0,1,0,0}, '{0,0,1,1}, '{0,1,0,1}, '{0,1,0,1}, '{0,0,0,1}};
    sat_exp  = '{1, 2, 3, 3, 3, 1};
    gap_bits = '{1, 0, 1};

    rst = 1'b1;
    bus_a.cfg_we = 0; bus_a.cfg_pattern = '0; bus_a.cfg_len = '0; bus_a.cfg_overlap = 0;
    bus_a.enable = 0; bus_a.din_valid = 0; bus_a.din = 0; bus_a.clr_count = 0;
    bus_b.cfg_we = 0; bus_b.cfg_pattern = '0; bus_b.cfg_len = '0; bus_b.cfg_overlap = 0;
    bus_b.enable = 0; bus_b.din_valid = 0; bus_b.din = 0; bus_b.clr_count = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_detect", bus_a.detect, 0);
    chk("rst_count",  bus_a.match_count, 0);
    chk("rst_armed",  bus_a.armed, 0);
    chk("rst_state",  bus_a.state, UNCFG);
    rst = 1'b0;

    // Saturation on a 2-bit counter, clear coinciding with a match.
    bus_b.cfg_we = 1; bus_b.cfg_len = 3'd1; bus_b.cfg_pattern = 4'b0001;
    @(posedge clk); #1;
    bus_b.cfg_we = 0; bus_b.enable = 1;
    @(posedge clk); #1;
    chk("b_armed", bus_b.armed, 1);
    bus_b.din_valid = 1; bus_b.din = 1;
    for (int k = 0; k < 6; k++) begin
      bus_b.clr_count = (k == 5);
      @(posedge clk); #1;
      chk("b_sat_cnt", bus_b.match_count, sat_exp[k]);
      chk("b_sat_det", bus_b.detect, 1);
    end
    bus_b.din_valid = 0; bus_b.clr_count = 0;
    bus_b.cfg_we = 1; bus_b.cfg_len = 3'd5;
    @(posedge clk); #1;
    bus_b.cfg_we = 0;
    chk("b_len_err", bus_b.cfg_err, 1);
    chk("b_len_keep_armed", bus_b.armed, 1);

    // Pattern 0110 over 0110110, overlapping then non-overlapping.
    bus_a.enable = 1;
    for (int i = 0; i < 14; i++) begin
      if (i == 0 || i == 7) begin
        configure(4, 16'h0006, tbl[i].ovl);
        clear_cnt();
      end
      send_bit(tbl[i].din);
      chk("tbl_det", bus_a.detect, tbl[i].exp_det);
      chk("tbl_cnt", bus_a.match_count, tbl[i].exp_cnt);
    end

    // Pattern 101 with random idle gaps between bits.
    configure(3, 16'h0005, 0);
    clear_cnt();
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 3)) step();
      send_bit(gap_bits[i]);
    end
    chk("gap_det", bus_a.detect, 1);
    step();
    chk("gap_pulse_end", bus_a.detect, 0);
    chk("gap_cnt", bus_a.match_count, 1);

    // Asynchronous reset in the middle of a pattern.
    configure(4, 16'h0006, 1);
    send_bit(0); send_bit(1); send_bit(1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_detect", bus_a.detect, 0);
    chk("arst_count",  bus_a.match_count, 0);
    chk("arst_armed",  bus_a.armed, 0);
    chk("arst_state",  bus_a.state, UNCFG);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    send_bit(0);
    chk("arst_no_det", bus_a.detect, 0);
    chk("arst_uncfg",  bus_a.state, UNCFG);

    // Out-of-range lengths are rejected while unconfigured.
    configure(0, 16'h0001, 0);
    chk("len0_err",   bus_a.cfg_err, 1);
    chk("len0_state", bus_a.state, UNCFG);
    configure(ML + 1, 16'h0001, 0);
    chk("len17_err",   bus_a.cfg_err, 1);
    chk("len17_state", bus_a.state, UNCFG);
    chk("len17_armed", bus_a.armed, 0);
    step();
    chk("err_pulse_end", bus_a.cfg_err, 0);

    // Randomized traffic.
    for (int r = 0; r < 6; r++) begin
      configure($urandom_range(1, 6), ML'($urandom), 1'($urandom_range(0, 1)));
      for (int c = 0; c < 200; c++) begin
        bus_a.din_valid = ($urandom_range(0, 9) < 7);
        bus_a.din       = 1'($urandom_range(0, 1));
        bus_a.enable    = ($urandom_range(0, 19) != 0);
        bus_a.clr_count = ($urandom_range(0, 49) == 0);
        bus_a.cfg_we    = ($urandom_range(0, 99) == 0);
        if (bus_a.cfg_we) begin
          bus_a.cfg_len     = 5'($urandom_range(0, ML + 1));
          bus_a.cfg_pattern = ML'($urandom);
          bus_a.cfg_overlap = 1'($urandom_range(0, 1));
        end
        step();
      end
      bus_a.din_valid = 0; bus_a.clr_count = 0; bus_a.cfg_we = 0; bus_a.enable = 1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
